// File: rtl/acc_mem_responder.sv
// Memory-side responder for the accumulator CPU rd/wr bus: serialized single-port RAM
// access with programmable wait states, a one-cycle ready pulse and a host preload port.
module acc_mem_responder #(
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned WAIT_CYC = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  output logic              busy,
  output logic              err,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ack
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_HOLD} state_t;

  state_t              state, state_nx;
  logic [CNT_W-1:0]    cnt, cnt_nx;
  logic                op_wr, op_wr_nx;
  logic [ADDR_W-1:0]   lat_addr, lat_addr_nx;
  logic [DATA_W-1:0]   lat_data, lat_data_nx;
  logic                ready_nx, err_nx, ld_ack_nx;
  logic                mem_we, rd_en;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W-1:0]   mem [DEPTH];

  // Next-state, latch and memory-port decode; CPU strobes outrank the host port in IDLE.
  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    op_wr_nx    = op_wr;
    lat_addr_nx = lat_addr;
    lat_data_nx = lat_data;
    ready_nx    = 1'b0;
    err_nx      = 1'b0;
    ld_ack_nx   = 1'b0;
    mem_we      = 1'b0;
    mem_waddr   = lat_addr;
    mem_wdata   = lat_data;
    rd_en       = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (rd && wr) begin
          err_nx = 1'b1;
        end else if (rd || wr) begin
          op_wr_nx    = wr;
          lat_addr_nx = addr;
          lat_data_nx = wdata;
          if (WAIT_CYC == 0) begin
            state_nx = S_ACCESS;
          end else begin
            cnt_nx   = CNT_W'(WAIT_CYC);
            state_nx = S_WAIT;
          end
        end else if (ld_en) begin
          mem_we    = 1'b1;
          mem_waddr = ld_addr;
          mem_wdata = ld_data;
          ld_ack_nx = 1'b1;
        end
      end
      S_WAIT: begin
        cnt_nx = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) state_nx = S_ACCESS;
      end
      S_ACCESS: begin
        ready_nx = 1'b1;
        state_nx = S_HOLD;
        if (op_wr) mem_we = 1'b1;
        else       rd_en  = 1'b1;
      end
      S_HOLD: begin
        if (!rd && !wr) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      op_wr    <= 1'b0;
      lat_addr <= '0;
      lat_data <= '0;
      rdata    <= '0;
      ready    <= 1'b0;
      err      <= 1'b0;
      ld_ack   <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      op_wr    <= op_wr_nx;
      lat_addr <= lat_addr_nx;
      lat_data <= lat_data_nx;
      ready    <= ready_nx;
      err      <= err_nx;
      ld_ack   <= ld_ack_nx;
      if (rd_en) rdata <= mem[lat_addr];
    end
  end

  // RAM contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign busy = (state == S_WAIT) || (state == S_ACCESS);

endmodule

// File: tb/tb_acc_mem_responder.sv
// Scoreboard bench for acc_mem_responder: three instances with WAIT_CYC = 0, 2 and 3.
module tb_acc_mem_responder;

  localparam int N = 3;

  typedef struct {
    int         inst;
    logic [7:0] data;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       rd_s      [N];
  logic       wr_s      [N];
  logic [4:0] addr_s    [N];
  logic [7:0] wdata_s   [N];
  logic [7:0] rdata_s   [N];
  logic       ready_s   [N];
  logic       busy_s    [N];
  logic       err_s     [N];
  logic       ld_en_s   [N];
  logic [4:0] ld_addr_s [N];
  logic [7:0] ld_data_s [N];
  logic       ld_ack_s  [N];

  int         checks;
  int         failures;
  int         rdy_cnt [N];
  logic [7:0] model   [N][32];
  logic [7:0] last_rd [N];
  exp_t       sb [$];
  exp_t       mon_e;

  for (genvar g = 0; g < N; g++) begin : g_dut
    acc_mem_responder #(
      .ADDR_W  (5),
      .DATA_W  (8),
      .WAIT_CYC((g == 0) ? 0 : (g == 1) ? 2 : 3)
    ) dut (
      .clk    (clk),
      .rst    (rst),
      .rd     (rd_s[g]),
      .wr     (wr_s[g]),
      .addr   (addr_s[g]),
      .wdata  (wdata_s[g]),
      .rdata  (rdata_s[g]),
      .ready  (ready_s[g]),
      .busy   (busy_s[g]),
      .err    (err_s[g]),
      .ld_en  (ld_en_s[g]),
      .ld_addr(ld_addr_s[g]),
      .ld_data(ld_data_s[g]),
      .ld_ack (ld_ack_s[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int wc(input int i);
    return (i == 0) ? 0 : (i == 1) ? 2 : 3;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Every ready pulse is matched against the oldest expected result.
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (ready_s[i]) begin
        rdy_cnt[i]++;
        check("ready_vs_ld_ack", 32'(ld_ack_s[i]), 0);
        if (sb.size() == 0) begin
          check("unexpected_ready", 32'(ready_s[i]), 0);
        end else begin
          mon_e = sb.pop_front();
          check("sb_inst", i, mon_e.inst);
          check("rdata", 32'(rdata_s[i]), 32'(mon_e.data));
        end
      end
    end
  end

  task automatic preload(input int i, input logic [4:0] a, input logic [7:0] d);
    @(negedge clk);
    ld_en_s[i] = 1'b1; ld_addr_s[i] = a; ld_data_s[i] = d;
    model[i][a] = d;
    @(negedge clk);
    check("ld_ack", 32'(ld_ack_s[i]), 1);
    ld_en_s[i] = 1'b0;
    @(negedge clk);
    check("ld_ack_pulse", 32'(ld_ack_s[i]), 0);
  endtask

  task automatic access(input int i, input bit w, input logic [4:0] a, input logic [7:0] d,
                        input int hold);
    int lat, bsy, r0;
    bit got;
    @(negedge clk);
    addr_s[i] = a; wdata_s[i] = d; rd_s[i] = !w; wr_s[i] = w;
    if (w) begin
      model[i][a] = d;
      sb.push_back('{i, last_rd[i]});
    end else begin
      last_rd[i] = model[i][a];
      sb.push_back('{i, model[i][a]});
    end
    r0 = rdy_cnt[i]; lat = 0; bsy = 0; got = 1'b0;
    while (!got && lat < 40) begin
      @(negedge clk);
      lat++;
      if (busy_s[i]) bsy++;
      if (ready_s[i]) got = 1'b1;
    end
    check("latency", lat, wc(i) + 2);
    check("busy_cycles", bsy, wc(i) + 1);
    repeat (hold) @(negedge clk);
    rd_s[i] = 1'b0; wr_s[i] = 1'b0;
    repeat (2) @(negedge clk);
    check("ready_count", rdy_cnt[i] - r0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  r0, n;
    bit  got;
    checks = 0; failures = 0;
    rst = 1'b1;
    for (int i = 0; i < N; i++) begin
      rd_s[i] = 0; wr_s[i] = 0; addr_s[i] = '0; wdata_s[i] = '0;
      ld_en_s[i] = 0; ld_addr_s[i] = '0; ld_data_s[i] = '0;
      rdy_cnt[i] = 0; last_rd[i] = '0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      check("rst_rdata", 32'(rdata_s[i]), 0);
      check("rst_ready", 32'(ready_s[i]), 0);
      check("rst_busy", 32'(busy_s[i]), 0);
      check("rst_err", 32'(err_s[i]), 0);
      check("rst_ld_ack", 32'(ld_ack_s[i]), 0);
    end

    // Zero wait states: preload then read.
    preload(0, 5'd3, 8'hA5);
    preload(0, 5'd10, 8'h5A);
    access(0, 1'b0, 5'd3, 8'h00, 0);

    // Two wait states: write held for several cycles, single ready, then read back.
    preload(1, 5'd0, 8'h42);
    access(1, 1'b1, 5'd7, 8'h3C, 3);
    access(1, 1'b0, 5'd7, 8'h00, 0);

    // Conflicting strobes in IDLE.
    @(negedge clk);
    rd_s[0] = 1; wr_s[0] = 1; addr_s[0] = 5'd3; wdata_s[0] = 8'hEE; r0 = rdy_cnt[0];
    repeat (3) begin
      @(negedge clk);
      check("err_pulse", 32'(err_s[0]), 1);
      check("err_busy", 32'(busy_s[0]), 0);
    end
    rd_s[0] = 0; wr_s[0] = 0;
    @(negedge clk);
    check("err_clear", 32'(err_s[0]), 0);
    check("err_no_ready", rdy_cnt[0] - r0, 0);
    access(0, 1'b0, 5'd3, 8'h00, 0);

    // Host preload loses to a CPU read in the same cycle.
    @(negedge clk);
    rd_s[0] = 1; addr_s[0] = 5'd3;
    ld_en_s[0] = 1; ld_addr_s[0] = 5'd10; ld_data_s[0] = 8'h77;
    last_rd[0] = model[0][3];
    sb.push_back('{0, model[0][3]});
    @(negedge clk);
    check("ld_ack_blocked", 32'(ld_ack_s[0]), 0);
    ld_en_s[0] = 0;
    got = 1'b0; n = 0;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      if (ready_s[0]) got = 1'b1;
    end
    check("ld_rd_ready", 32'(got), 1);
    rd_s[0] = 0;
    repeat (2) @(negedge clk);
    access(0, 1'b0, 5'd10, 8'h00, 0);
    preload(0, 5'd10, 8'h77);
    access(0, 1'b0, 5'd10, 8'h00, 0);

    // Reset during WAIT aborts the write.
    preload(2, 5'd9, 8'h11);
    @(negedge clk);
    wr_s[2] = 1; addr_s[2] = 5'd9; wdata_s[2] = 8'hEE; r0 = rdy_cnt[2];
    @(negedge clk);
    check("rst_wait_busy", 32'(busy_s[2]), 1);
    rst = 1'b1; wr_s[2] = 0;
    #1;
    check("mid_rst_busy", 32'(busy_s[2]), 0);
    check("mid_rst_ready", 32'(ready_s[2]), 0);
    check("mid_rst_rdata", 32'(rdata_s[2]), 0);
    check("mid_rst_err", 32'(err_s[2]), 0);
    check("mid_rst_ld_ack", 32'(ld_ack_s[2]), 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < N; i++) last_rd[i] = '0;
    repeat (6) @(negedge clk);
    check("rst_no_ready", rdy_cnt[2] - r0, 0);
    access(2, 1'b0, 5'd9, 8'h00, 0);

    // Top address, no aliasing onto address 0.
    access(1, 1'b1, 5'd31, 8'hFF, 0);
    access(1, 1'b0, 5'd31, 8'h00, 0);
    access(1, 1'b0, 5'd0, 8'h00, 0);

    repeat (3) @(negedge clk);
    check("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/acc_mem_responder.md
Name: acc_mem_responder

Overview:
- Memory-side responder for the accumulator CPU's rd/wr bus.
- Services the level-strobed rd and wr requests from the control FSM against a single-port data/program RAM.
- Inserts a programmable number of wait states and reports completion with a one-cycle ready pulse; the CPU's stall logic uses that pulse.
- Provides a host preload port so a program image can be written into the RAM while the CPU bus is idle.

Parameters:
- ADDR_W, 5, address width; RAM depth is 2**ADDR_W words.
- DATA_W, 8, word width (instruction = 3-bit op + ADDR_W operand when DATA_W = ADDR_W+3).
- WAIT_CYC, 1, wait states inserted before each access; legal range 0..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- rd  in  1  CPU read strobe, level.
- wr  in  1  CPU write strobe, level.
- addr  in  ADDR_W  CPU address (IR operand field).
- wdata  in  DATA_W  CPU write data (accumulator).
- rdata  out  DATA_W  registered read data (to MDR).
- ready  out  1  one-cycle completion pulse, registered.
- busy  out  1  high in WAIT and ACCESS; decode of the state register.
- err  out  1  one-cycle pulse when rd and wr are sampled high together.
- ld_en  in  1  host preload write request.
- ld_addr  in  ADDR_W  host preload address.
- ld_data  in  DATA_W  host preload data.
- ld_ack  out  1  one-cycle pulse: host write committed.

Behaviour:
- Reset (async, any state): state=IDLE, rdata=0, ready=0, err=0, ld_ack=0, wait counter=0, latched op/addr/data cleared. RAM contents are not reset.
- States: IDLE, WAIT, ACCESS, HOLD.
- IDLE, rd XOR wr sampled high:
  - Latch op, addr and wdata.
  - WAIT_CYC=0: go to ACCESS.
  - Otherwise: cnt<=WAIT_CYC, go to WAIT.
- IDLE, rd and wr both high:
  - err<=1 for one cycle, no access, stay in IDLE.
  - Re-evaluated every cycle, so err re-pulses each cycle the condition persists.
- IDLE, rd=wr=0, ld_en=1: mem[ld_addr]<=ld_data, ld_ack<=1 for one cycle. CPU strobes always take priority over ld_en in the same cycle; ld_en is ignored outside IDLE.
- WAIT: cnt decrements each edge; when cnt==1, go to ACCESS. Strobe or address changes during WAIT are ignored because the latched values are used.
- ACCESS, one edge:
  - Read: rdata<=mem[latched addr].
  - Write: mem[latched addr]<=latched wdata; rdata holds its previous value.
  - Either op: ready<=1 for exactly one cycle, then go to HOLD.
- HOLD: stay until rd=0 and wr=0 are sampled, then go to IDLE. A held strobe never triggers a second access. If the strobe drops in the cycle of ready, HOLD lasts one cycle.
- Latency: with the strobe sampled at edge k, ready is high from edge k+1+WAIT_CYC to edge k+2+WAIT_CYC. rdata is valid in the same cycle as ready and holds until the next read completes.
- Read-after-write to the same address returns the newly written data. No bypass is needed because accesses are serialized.
- Reset during WAIT or before the ACCESS edge: the write is not committed and ready is not issued.
- ld_ack and ready are never high in the same cycle.

Test Plan:
- WAIT_CYC=0: preload mem[3]=0xA5 via ld_en (ld_ack one cycle later); rd=1, addr=3 sampled at edge k -> ready high after edge k+1, rdata=0xA5, busy high for one cycle.
- WAIT_CYC=2: wr=1, addr=7, wdata=0x3C held high for 6 cycles -> ready single pulse after edge k+3, exactly one write, no second ready; then rd addr=7 -> rdata=0x3C.
- rd=1 and wr=1 sampled together in IDLE -> err pulses, RAM unchanged, ready stays 0, state remains IDLE.
- ld_en=1 asserted in the same cycle as rd=1 -> read serviced, ld_ack=0, mem[ld_addr] unchanged; ld_en re-presented after return to IDLE -> ld_ack=1, data written.
- WAIT_CYC=3: wr to addr 9 with mem[9]=0x11, rst pulsed during WAIT -> all outputs 0, mem[9] still 0x11.
- Address 2**ADDR_W-1 (31): write 0xFF, read back 0xFF; mem[0] is unaffected (no wrap aliasing).
